// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA frame-buffer path.
// Holds the default visible resolution, the packed 4:4:4 pixel type,
// the scanout arbiter state encoding and the colour shown on underflow.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } arb_state_t;

    localparam rgb_t UNDERFLOW_RGB = '{r: 4'h0, g: 4'h0, b: 4'h0};

endpackage

// File: rtl/vram_prefetch_fifo.sv
// Synchronous prefetch FIFO holding scanout pixels ahead of the beam.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   flush               - empties the FIFO; wins over push and pop
//   push, push_data     - write one word
//   pop                 - discard the head word
//   head_data           - current head word (combinational)
//   occupancy           - number of stored words
//   empty, full         - status flags
module vram_prefetch_fifo #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  occupancy,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign empty     = (count_r == CNT_W'(0));
    assign full      = (count_r == CNT_W'(DEPTH));
    assign occupancy = count_r;
    assign head_data = mem_r[rd_ptr_r];

    // A push into a full FIFO is only legal when a pop frees a slot in the same cycle.
    assign push_ok_s = push && (!full || pop);
    assign pop_ok_s  = pop && !empty;

    // Storage array write; contents need no reset because count gates the head.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Arbiter sharing one single-port pixel memory between VGA scanout and a
// pixel writer. Scanout reads run ahead of the beam into a prefetch FIFO
// and always win the memory; every other cycle is offered to the writer.
// Optional statistics counters are built when VRAM_ARB_STATS_EN is defined.
// Ports:
//   clk_main, rst_n              - clock, asynchronous active-low reset
//   pixel_ce, blank, frame_start - timing from vga_controller
//   wr_valid/wr_ready/wr_addr/wr_data - writer handshake
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - frame-buffer BRAM port
//   pix_rgb                      - registered pixel to the DAC
//   underflow                    - sticky, cleared by frame_start
//   underflow_cnt, wr_stall_cnt  - saturating counters (VRAM_ARB_STATS_EN)
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk_main,
    input  logic              rst_n,
    input  logic              pixel_ce,
    input  logic              blank,
    input  logic              frame_start,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_rgb,
    output logic              underflow
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [15:0]       underflow_cnt,
    output logic [15:0]       wr_stall_cnt
`endif
);

    localparam int TOTAL = H_ACTIVE * V_ACTIVE;
    // One extra bit so the fetch address can represent TOTAL itself.
    localparam int FA_W  = ADDR_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BUD_W = CNT_W + 1;

    arb_state_t        state_r;
    logic [FA_W-1:0]   fetch_addr_r;
    logic              inflight_r;

    logic [CNT_W-1:0]  occupancy_s;
    logic              empty_s;
    logic              full_s;
    logic [DATA_W-1:0] head_s;
    logic [BUD_W-1:0]  budget_s;
    logic              fetch_issue_s;
    logic              push_s;
    logic              pop_req_s;
    logic              pop_s;
    logic              underflow_pop_s;

    // Words already stored plus the one possibly on its way back must fit.
    assign budget_s      = {1'b0, occupancy_s} + BUD_W'(inflight_r);
    assign fetch_issue_s = (state_r == S_FETCH) && !full_s &&
                           (budget_s < BUD_W'(FIFO_DEPTH));

    // A read issued in the frame_start cycle still reaches the memory, but
    // inflight is cleared so its return is dropped.
    assign push_s          = inflight_r && !frame_start;
    assign pop_req_s       = pixel_ce && !blank && !frame_start;
    assign pop_s           = pop_req_s && !empty_s;
    assign underflow_pop_s = pop_req_s && empty_s;

    vram_prefetch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_main),
        .rst_n     (rst_n),
        .flush     (frame_start),
        .push      (push_s),
        .push_data (mem_rdata),
        .pop       (pop_s),
        .head_data (head_s),
        .occupancy (occupancy_s),
        .empty     (empty_s),
        .full      (full_s)
    );

    // Memory port mux: scanout read first, otherwise the writer passes straight through.
    always_comb begin
        wr_ready  = 1'b1;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (fetch_issue_s) begin
            wr_ready = 1'b0;
            mem_en   = 1'b1;
            mem_addr = fetch_addr_r[ADDR_W-1:0];
        end else if (wr_valid) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end else begin
            mem_en = 1'b0;
        end
    end

    // Scanout FSM with fetch address and in-flight tracking.
    always_ff @(posedge clk_main or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_WAIT;
            fetch_addr_r <= '0;
            inflight_r   <= 1'b0;
        end else if (frame_start) begin
            state_r      <= S_FETCH;
            fetch_addr_r <= '0;
            inflight_r   <= 1'b0;
        end else begin
            inflight_r <= fetch_issue_s;
            if (fetch_issue_s) begin
                fetch_addr_r <= fetch_addr_r + FA_W'(1);
            end
            case (state_r)
                S_FETCH: begin
                    if (fetch_issue_s && (fetch_addr_r == FA_W'(TOTAL - 1))) begin
                        state_r <= S_DONE;
                    end
                end
                S_WAIT:  state_r <= S_WAIT;
                S_DONE:  state_r <= S_DONE;
                default: state_r <= S_WAIT;
            endcase
        end
    end

    // Pixel output register and sticky underflow flag.
    always_ff @(posedge clk_main or negedge rst_n) begin
        if (!rst_n) begin
            pix_rgb   <= '0;
            underflow <= 1'b0;
        end else if (frame_start) begin
            underflow <= 1'b0;
            if (pixel_ce) begin
                pix_rgb <= DATA_W'(UNDERFLOW_RGB);
            end
        end else if (pixel_ce) begin
            if (blank) begin
                pix_rgb <= '0;
            end else if (!empty_s) begin
                pix_rgb <= head_s;
            end else begin
                pix_rgb   <= DATA_W'(UNDERFLOW_RGB);
                underflow <= 1'b1;
            end
        end
    end

`ifdef VRAM_ARB_STATS_EN
    // Saturating per-frame statistics.
    always_ff @(posedge clk_main or negedge rst_n) begin
        if (!rst_n) begin
            underflow_cnt <= 16'h0000;
            wr_stall_cnt  <= 16'h0000;
        end else if (frame_start) begin
            underflow_cnt <= 16'h0000;
            wr_stall_cnt  <= 16'h0000;
        end else begin
            if (underflow_pop_s && (underflow_cnt != 16'hFFFF)) begin
                underflow_cnt <= underflow_cnt + 16'h0001;
            end
            if (wr_valid && !wr_ready && (wr_stall_cnt != 16'hFFFF)) begin
                wr_stall_cnt <= wr_stall_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares one single-port pixel memory between the VGA scanout path and a pixel-writing requester. Fetches display pixels ahead of the beam into a prefetch FIFO with absolute priority, grants every spare memory cycle to the writer through a valid/ready handshake, and delivers one RGB word per visible pixel to `vga_controller`. Sits between `vga_controller` (timing: `drawX`, `drawY`, `blank`) and the frame-buffer BRAM.

## Interface
- `H_ACTIVE`, default 640: visible pixels per line.
- `V_ACTIVE`, default 480: visible lines per frame.
- `ADDR_W`, default 19: memory address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
- `DATA_W`, default 12: pixel width, 4:4:4 RGB.
- `FIFO_DEPTH`, default 16: prefetch depth; power of two, at least 4.

- `clk_main` in 1: 100 MHz system clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pixel_ce` in 1: one-cycle pixel strobe, 1 in 4 `clk_main` cycles.
- `blank` in 1: high outside the visible area.
- `frame_start` in 1: one-cycle pulse on the first non-visible line after line V_ACTIVE-1.
- `wr_valid` in 1: writer request.
- `wr_ready` out 1: writer grant.
- `wr_addr` in ADDR_W: writer address.
- `wr_data` in DATA_W: writer data.
- `mem_en` out 1: memory enable.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data, valid 1 cycle after a read.
- `pix_rgb` out DATA_W: registered pixel to DAC.
- `underflow` out 1: sticky underflow flag.

## Operation
- States:
  - `S_WAIT`: entered on reset. Only writes are granted. Exit to `S_FETCH` on `frame_start`.
  - `S_FETCH`: scanout reads have priority. Exit to `S_DONE` when fetch address reaches H_ACTIVE*V_ACTIVE.
  - `S_DONE`: only writes are granted. Exit to `S_FETCH` on `frame_start`.
- Fetch request: in `S_FETCH` and `occupancy + inflight < FIFO_DEPTH`.
- Grant rules:
  - Fetch cycle: `mem_en`=1, `mem_we`=0, `mem_addr`=fetch address. Fetch address increments by 1 per issued read, linear from 0.
  - Otherwise: `wr_ready`=1.
  - `wr_valid && wr_ready`: `mem_en`=1, `mem_we`=1, `mem_addr`/`mem_wdata` equal `wr_addr`/`wr_data`.
  - A write is accepted in the same cycle; the writer holds its address and data while `wr_ready`=0.
- Read return: `mem_rdata` is pushed into the FIFO in the cycle after the read. `inflight` is 0 or 1.
- Pop: on `pixel_ce && !blank`.
  - FIFO non-empty: `pix_rgb` takes the head word.
  - FIFO empty: `pix_rgb` takes the underflow colour (all zero), and `underflow` is set.
- On `pixel_ce && blank`: `pix_rgb` becomes 0.
- `frame_start` in any state:
  - Flush FIFO and clear fetch address.
  - Mark any in-flight read as discarded; its return is not pushed.
  - Clear `underflow`.
  - `frame_start` wins over a simultaneous pop, push or fetch issue.
- Writes targeting addresses at or beyond H_ACTIVE*V_ACTIVE are accepted and passed through unchanged.

## Timing
- Reset values:
  - State `S_WAIT`.
  - `pix_rgb`=0, `underflow`=0, FIFO empty, fetch address 0.
  - `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `wr_ready`=1.
- `mem_*` and `wr_ready` are combinational from registered state, `wr_valid`, `wr_addr` and `wr_data`.
- Bandwidth: steady-state scanout uses at most 1 in 4 cycles, leaving the writer at least 3 in 4 during active video.
- FIFO fills within FIFO_DEPTH+1 cycles after `frame_start`, well inside vertical blank.
- Pixel latency: FIFO head to `pix_rgb` is 1 cycle, registered on `pixel_ce`.

## Configuration
- `VRAM_ARB_STATS_EN` defined:
  - Adds output `underflow_cnt` [15:0], counting underflow pops and saturating at 0xFFFF.
  - Adds output `wr_stall_cnt` [15:0], counting cycles with `wr_valid && !wr_ready`, saturating.
  - Both counters clear on `frame_start` and on reset.
- `VRAM_ARB_STATS_EN` undefined: neither port nor any counter logic exists.

## Structure
- `vga_pkg` holds:
  - `H_ACTIVE`/`V_ACTIVE` defaults.
  - `rgb_t` (packed 4:4:4).
  - `arb_state_t` enum (`S_WAIT`, `S_FETCH`, `S_DONE`).
  - `UNDERFLOW_RGB` constant.
- One sub-module: `vram_prefetch_fifo`, a synchronous FIFO with flush, push, pop, `occupancy` and empty/full.

## Test plan
- Reset, then `wr_valid`=1 with no `frame_start` -> `wr_ready`=1 every cycle; each write appears on `mem_*` with `mem_we`=1.
- `frame_start` with memory preloaded `addr`=value -> first 16 cycles are reads of addresses 0..15; the first visible pops give `pix_rgb`=0x000,0x001,0x002.
- Writer asserting continuously during active video -> exactly 1 read per 4 cycles in steady state, `wr_stall_cnt` increases by 1 per read, `underflow`=0 for the whole frame.
- Memory read returns held off (model forces FIFO empty) while a visible `pixel_ce` arrives -> `pix_rgb`=0x000, `underflow`=1; next `frame_start` clears it to 0.
- `frame_start` in the same cycle a read is in flight and a pop occurs -> returned word discarded, FIFO empty, next read address 0.
- Full frame of 640x480 pops -> the last read is address 307199, state becomes `S_DONE`, and no further reads occur until `frame_start`.
